// File: rtl/pipe_pkg.sv
// Definitions shared by every generic pipeline stage register: occupancy
// encoding, default bubble control word and control-vector field positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    localparam int unsigned CTRL_W_DEFAULT = 8;
    localparam logic [CTRL_W_DEFAULT-1:0] BUBBLE_CTRL_DEFAULT = 8'h00;

    // Bit positions inside the control vector, so every stage packs and
    // unpacks in_ctrl the same way.
    localparam int unsigned CTRL_REG_WE     = 0;
    localparam int unsigned CTRL_MEM_WE     = 1;
    localparam int unsigned CTRL_MEM_RE     = 2;
    localparam int unsigned CTRL_JUMP       = 3;
    localparam int unsigned CTRL_BRANCH     = 4;
    localparam int unsigned CTRL_ALU_SRC    = 5;
    localparam int unsigned CTRL_MEM_TO_REG = 6;
    localparam int unsigned CTRL_HALT       = 7;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with ready/valid handshake, synchronous
// flush, bubble control word, optional two-entry skid buffer and statistics.
import pipe_pkg::*;

module pipe_stage_skid #(
    parameter int unsigned       DATA_W      = 96,
    parameter int unsigned       CTRL_W      = CTRL_W_DEFAULT,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEFAULT),
    parameter int unsigned       SKID        = 1,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: an entry moves on a clock edge where valid and ready are both
    // high; valid never depends on ready, and a held entry stays stable until taken.
    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              push;
    logic              pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign dbg_state = state_q;

    // With the skid entry present, in_ready comes only from state flops.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state_q != ST_TWO);
        end else begin : g_single
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = BUBBLE_CTRL;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (push && (SKID != 0)) begin
                        state_d     = ST_TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (pop) begin
                        state_d     = ST_EMPTY;
                        main_data_d = '0;
                        main_ctrl_d = BUBBLE_CTRL;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_data_d = '0;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_data_d = '0;
                    main_ctrl_d = BUBBLE_CTRL;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= BUBBLE_CTRL;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready & ~flush),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid, single-register and narrow-counter
// instances, with a queue scoreboard tracking every accepted entry.
module tb_pipe_stage_skid;

  localparam int DW = 96;
  localparam int CW = 8;
  localparam logic [7:0] BUB_A = 8'hA5;
  localparam logic [7:0] BUB_C = 8'h5A;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // instance a: skid buffer, 16-bit counters
  logic a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [DW-1:0] a_in_data = '0;
  logic [CW-1:0] a_in_ctrl = '0;
  logic a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [CW-1:0] a_out_ctrl;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic [1:0] a_dbg;

  // instance b: single register
  logic b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [DW-1:0] b_in_data = '0;
  logic [CW-1:0] b_in_ctrl = '0;
  logic b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [CW-1:0] b_out_ctrl;
  logic [15:0] b_stall_cnt, b_flush_cnt;
  logic [1:0] b_dbg;

  // instance c: 4-bit counters
  logic c_flush = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [15:0] c_in_data = '0;
  logic [CW-1:0] c_in_ctrl = '0;
  logic c_in_ready, c_out_valid;
  logic [15:0] c_out_data;
  logic [CW-1:0] c_out_ctrl;
  logic [3:0] c_stall_cnt, c_flush_cnt;
  logic [1:0] c_dbg;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB_A), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt),
    .dbg_state(a_dbg));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB_A), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt),
    .dbg_state(b_dbg));

  pipe_stage_skid #(.DATA_W(16), .CTRL_W(CW), .BUBBLE_CTRL(BUB_C), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_ctrl(c_in_ctrl), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_ctrl(c_out_ctrl), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt),
    .dbg_state(c_dbg));

  // Scoreboard: accepted entries queue up, each pop must match the oldest one.
  logic [CW+DW-1:0] a_q[$];
  logic [CW+DW-1:0] b_q[$];

  always @(negedge clk) begin
    logic [CW+DW-1:0] exp_v;
    if (reset) begin
      a_q.delete();
      b_q.delete();
    end else begin
      vec_cnt++;
      if (a_out_valid !== (a_q.size() != 0)) begin
        err_cnt++;
        $display("FAIL a_occupancy: out_valid=%b, required %0d held", a_out_valid, a_q.size());
      end
      vec_cnt++;
      if (a_in_ready !== (a_q.size() < 2)) begin
        err_cnt++;
        $display("FAIL a_in_ready: got %b with %0d held", a_in_ready, a_q.size());
      end
      if (!a_out_valid) begin
        vec_cnt++;
        if ({a_out_ctrl, a_out_data} !== {BUB_A, {DW{1'b0}}}) begin
          err_cnt++;
          $display("FAIL a_bubble: ctrl=%h data=%h, required ctrl=%h data=0", a_out_ctrl, a_out_data, BUB_A);
        end
      end
      if (a_flush) begin
        a_q.delete();
      end else begin
        if (a_out_valid && a_out_ready && a_q.size() != 0) begin
          exp_v = a_q.pop_front();
          vec_cnt++;
          if ({a_out_ctrl, a_out_data} !== exp_v) begin
            err_cnt++;
            $display("FAIL a_order: got %h, required %h", {a_out_ctrl, a_out_data}, exp_v);
          end
        end
        if (a_in_valid && a_in_ready) a_q.push_back({a_in_ctrl, a_in_data});
      end

      vec_cnt++;
      if (b_out_valid !== (b_q.size() != 0)) begin
        err_cnt++;
        $display("FAIL b_occupancy: out_valid=%b, required %0d held", b_out_valid, b_q.size());
      end
      vec_cnt++;
      if (b_in_ready !== ((b_q.size() == 0) || b_out_ready)) begin
        err_cnt++;
        $display("FAIL b_in_ready: got %b with %0d held, out_ready=%b", b_in_ready, b_q.size(), b_out_ready);
      end
      if (b_flush) begin
        b_q.delete();
      end else begin
        if (b_out_valid && b_out_ready && b_q.size() != 0) begin
          exp_v = b_q.pop_front();
          vec_cnt++;
          if ({b_out_ctrl, b_out_data} !== exp_v) begin
            err_cnt++;
            $display("FAIL b_order: got %h, required %h", {b_out_ctrl, b_out_data}, exp_v);
          end
        end
        if (b_in_valid && b_in_ready) b_q.push_back({b_in_ctrl, b_in_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_out_ready = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b, required 0", a_out_valid); end
    vec_cnt++; if (a_out_ctrl !== BUB_A) begin err_cnt++; $display("FAIL reset_out_ctrl: got %h, required %h", a_out_ctrl, BUB_A); end
    vec_cnt++; if (a_out_data !== '0) begin err_cnt++; $display("FAIL reset_out_data: got %h, required 0", a_out_data); end
    vec_cnt++; if (a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %b, required 1", a_in_ready); end
    vec_cnt++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin err_cnt++; $display("FAIL reset_counters: got %0d/%0d, required 0/0", a_stall_cnt, a_flush_cnt); end
    vec_cnt++; if (b_in_ready !== 1'b1 || b_out_ctrl !== BUB_A) begin err_cnt++; $display("FAIL reset_single: in_ready=%b ctrl=%h, required 1/%h", b_in_ready, b_out_ctrl, BUB_A); end
    vec_cnt++; if (c_out_ctrl !== BUB_C) begin err_cnt++; $display("FAIL reset_c_ctrl: got %h, required %h", c_out_ctrl, BUB_C); end
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    reset_all();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      a_in_valid = 1'b1;
      a_in_data = DW'(i);
      a_in_ctrl = 8'($urandom_range(0, 255));
      tick();
      vec_cnt++;
      if (a_out_valid !== 1'b1 || a_out_data !== DW'(i)) begin
        err_cnt++;
        $display("FAIL stream_latency: valid=%b data=%0d, required 1/%0d", a_out_valid, a_out_data, i);
      end
    end
    a_in_valid = 1'b0;
    tick();
    tick();
    vec_cnt++; if (a_stall_cnt !== 16'd0) begin err_cnt++; $display("FAIL stream_stall: got %0d, required 0", a_stall_cnt); end
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_drain: out_valid=%b, required 0", a_out_valid); end
  endtask

  task automatic test_backpressure();
    reset_all();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = DW'(8'h11); a_in_ctrl = 8'h01;
    tick();
    a_in_data = DW'(8'h22); a_in_ctrl = 8'h02;
    vec_cnt++; if (a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_one: got %b, required 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vec_cnt++;
      if (a_in_ready !== 1'b0 || a_out_data !== DW'(8'h11) || a_out_ctrl !== 8'h01) begin
        err_cnt++;
        $display("FAIL bp_hold: in_ready=%b data=%h ctrl=%h, required 0/11/01", a_in_ready, a_out_data, a_out_ctrl);
      end
      if (k < 4) tick();
    end
    vec_cnt++; if (a_stall_cnt !== 16'd5) begin err_cnt++; $display("FAIL bp_stall_cnt: got %0d, required 5", a_stall_cnt); end
    a_out_ready = 1'b1;
    tick();
    vec_cnt++;
    if (a_out_data !== DW'(8'h22) || a_in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_release: data=%h in_ready=%b, required 22/1", a_out_data, a_in_ready);
    end
    tick();
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_empty: out_valid=%b, required 0", a_out_valid); end
  endtask

  task automatic test_flush();
    reset_all();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = DW'(8'h11); a_in_ctrl = 8'h11;
    tick();
    a_in_data = DW'(8'h22); a_in_ctrl = 8'h22;
    tick();
    a_flush = 1'b1; a_in_data = DW'(8'h33); a_in_ctrl = 8'h33;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    vec_cnt++;
    if (a_out_valid !== 1'b0 || a_out_ctrl !== BUB_A || a_out_data !== '0) begin
      err_cnt++;
      $display("FAIL flush_two: valid=%b ctrl=%h data=%h, required 0/%h/0", a_out_valid, a_out_ctrl, a_out_data, BUB_A);
    end
    vec_cnt++; if (a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_ready: got %b, required 1", a_in_ready); end
    vec_cnt++; if (a_flush_cnt !== 16'd1) begin err_cnt++; $display("FAIL flush_cnt1: got %0d, required 1", a_flush_cnt); end
    vec_cnt++; if (a_dbg !== 2'd0) begin err_cnt++; $display("FAIL flush_state: got %0d, required 0", a_dbg); end
    // flush while holding one entry, with an accepted push and a pop pending
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = DW'(8'h44); a_in_ctrl = 8'h44;
    tick();
    a_in_data = DW'(8'h55); a_in_ctrl = 8'h55; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_one: out_valid=%b, required 0", a_out_valid); end
    vec_cnt++; if (a_flush_cnt !== 16'd2) begin err_cnt++; $display("FAIL flush_cnt2: got %0d, required 2", a_flush_cnt); end
    tick();
    tick();
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_ghost: out_valid=%b data=%h, required 0", a_out_valid, a_out_data); end
    vec_cnt++; if (a_stall_cnt !== 16'd1) begin err_cnt++; $display("FAIL flush_stall: got %0d, required 1", a_stall_cnt); end
  endtask

  task automatic test_no_skid();
    reset_all();
    for (int i = 0; i < 12; i++) begin
      b_in_valid = 1'b1;
      b_in_data = DW'(32'h100 + i);
      b_in_ctrl = 8'(i);
      b_out_ready = (i % 2 == 0);
      #1;
      if (b_out_valid) begin
        vec_cnt++;
        if (b_in_ready !== b_out_ready) begin
          err_cnt++;
          $display("FAIL noskid_ready: in_ready=%b, required %b", b_in_ready, b_out_ready);
        end
      end
      vec_cnt++; if (b_dbg === 2'd2) begin err_cnt++; $display("FAIL noskid_state: got %0d, required 0 or 1", b_dbg); end
      tick();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if (b_out_valid !== 1'b0 || b_q.size() != 0) begin
      err_cnt++;
      $display("FAIL noskid_drain: out_valid=%b, %0d entries never delivered, required 0/0", b_out_valid, b_q.size());
    end
  endtask

  task automatic test_saturation();
    int exp_s;
    reset_all();
    c_flush = 1'b1;
    tick();
    c_flush = 1'b0;
    vec_cnt++; if (c_flush_cnt !== 4'd1) begin err_cnt++; $display("FAIL sat_flush_cnt: got %0d, required 1", c_flush_cnt); end
    c_out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_data = 16'hABCD; c_in_ctrl = 8'h3C;
    tick();
    c_in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_s = (n > 15) ? 15 : n;
      vec_cnt++;
      if (c_stall_cnt !== 4'(exp_s)) begin
        err_cnt++;
        $display("FAIL sat_stall_cnt: got %0d after %0d stalls, required %0d", c_stall_cnt, n, exp_s);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (c_out_valid !== 1'b0 || c_out_ctrl !== BUB_C || c_out_data !== 16'd0 || c_in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL async_reset_out: valid=%b ctrl=%h data=%h ready=%b, required 0/%h/0/1",
               c_out_valid, c_out_ctrl, c_out_data, c_in_ready, BUB_C);
    end
    vec_cnt++;
    if (c_stall_cnt !== 4'd0 || c_flush_cnt !== 4'd0 || c_dbg !== 2'd0) begin
      err_cnt++;
      $display("FAIL async_reset_cnt: stall=%0d flush=%0d state=%0d, required 0/0/0", c_stall_cnt, c_flush_cnt, c_dbg);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_no_skid();
    test_saturation();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    err_cnt++;
    $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

endmodule
